// File: rtl/sync_fifo_dp_pkg.sv
// Shared constants and helpers for the sync_fifo_dp FIFO and its RAM.
package sync_fifo_dp_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 64;

  // Number of entries for a given address width.
  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'(1) << aw;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Two-port RAM: synchronous write port, synchronous registered read port.
// Ports:
//   clk, rst_n          clock, async active-low reset (read register only)
//   we_i/waddr_i/din_i  write port
//   re_i/raddr_i/dout_o read port; dout_o holds when re_i is low
module fifo_dpram
  import sync_fifo_dp_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] din_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] dout_o
);

  localparam int unsigned DEPTH = fifo_depth(AW);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] dout_q;

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= din_i;
  end

  // Read data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    dout_q <= '0;
    else if (re_i) dout_q <= mem_q[raddr_i];
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/sync_fifo_dp.sv
// Single-clock FIFO: pointer/count controller around a two-port RAM.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   clear                      synchronous flush (beats read/write)
//   wr_en/din                  write request and data
//   rd_en/dout                 read request and registered read data
//   empty/almost_empty         count == 0 / count == 1
//   full/almost_full           count == depth / count == depth-1
//   waddr/raddr                current write/read pointers
//   wallow/rallow              write/read accepted this cycle
module sync_fifo_dp
  import sync_fifo_dp_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          almost_empty,
  output logic          full,
  output logic          almost_full,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] raddr,
  output logic          wallow,
  output logic          rallow
);

  localparam int unsigned DEPTH    = fifo_depth(AW);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_AF   = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;

  // Flags decoded from registered count only.
  always_comb begin
    empty        = (count_q == '0);
    almost_empty = (count_q == CNT_ONE);
    full         = (count_q == CNT_FULL);
    almost_full  = (count_q == CNT_AF);
  end

  // Accept logic; clear and reset suppress both ports.
  always_comb begin
    wallow = rst_n & wr_en & ~full  & ~clear;
    rallow = rst_n & rd_en & ~empty & ~clear;
  end

  // Next-state for pointers and occupancy.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wallow) wptr_d = wptr_q + AW'(1);
      if (rallow) rptr_d = rptr_q + AW'(1);
      unique case ({wallow, rallow})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign waddr = wptr_q;
  assign raddr = rptr_q;

  fifo_dpram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wallow),
    .waddr_i (wptr_q),
    .din_i   (din),
    .re_i    (rallow),
    .raddr_i (rptr_q),
    .dout_o  (dout)
  );

endmodule

// File: tb/tb_sync_fifo_dp.sv
module tb_sync_fifo_dp;

  localparam int AW    = 5;
  localparam int DW    = 64;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          empty, almost_empty, full, almost_full;
  logic [AW-1:0] waddr, raddr;
  logic          wallow, rallow;

  sync_fifo_dp dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .empty        (empty),
    .almost_empty (almost_empty),
    .full         (full),
    .almost_full  (almost_full),
    .waddr        (waddr),
    .raddr        (raddr),
    .wallow       (wallow),
    .rallow       (rallow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model
  int            mcount;
  logic [AW-1:0] mwp, mrp;
  logic [DW-1:0] mdout;
  logic [DW-1:0] sb [$];

  typedef struct {
    logic          w, r, c;
    logic [DW-1:0] d;
    logic          ew, er, ee, eae;
    logic [DW-1:0] edout;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mcount = 0;
    mwp    = '0;
    mrp    = '0;
    mdout  = '0;
    sb.delete();
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".empty"},  64'(empty),        64'(mcount == 0));
    chk({tag, ".aempty"}, 64'(almost_empty), 64'(mcount == 1));
    chk({tag, ".full"},   64'(full),         64'(mcount == DEPTH));
    chk({tag, ".afull"},  64'(almost_full),  64'(mcount == DEPTH - 1));
    chk({tag, ".waddr"},  64'(waddr),        64'(mwp));
    chk({tag, ".raddr"},  64'(raddr),        64'(mrp));
    chk({tag, ".dout"},   dout,              mdout);
  endtask

  // One clock cycle: drive, check accepts, clock, update model, check state.
  task automatic cyc(input logic w, input logic r, input logic c, input logic [DW-1:0] d,
                     output logic gw, output logic gr);
    logic ew, er;
    wr_en = w; rd_en = r; clear = c; din = d;
    ew = w & ~c & (mcount != DEPTH);
    er = r & ~c & (mcount != 0);
    #1;
    gw = wallow;
    gr = rallow;
    chk("wallow", 64'(wallow), 64'(ew));
    chk("rallow", 64'(rallow), 64'(er));
    @(posedge clk);
    #1;
    if (c) begin
      mcount = 0; mwp = '0; mrp = '0;
      sb.delete();
    end else begin
      if (er) begin mdout = sb.pop_front(); mrp = mrp + 1'b1; mcount--; end
      if (ew) begin sb.push_back(d); mwp = mwp + 1'b1; mcount++; end
    end
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    chk_state("cyc");
  endtask

  task automatic drain();
    logic gw, gr;
    for (int k = 0; k < 2 * DEPTH && mcount > 0; k++) cyc(1'b0, 1'b1, 1'b0, '0, gw, gr);
    chk("drain.done", 64'(mcount), 64'(0));
  endtask

  initial begin
    logic          gw, gr;
    logic [DW-1:0] hold_d, word;
    logic [AW-1:0] hold_a;
    int            pushed;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 64'h0,            1'b0, 1'b0, 1'b1, 1'b0, 64'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 64'hA5A5_0000_0001, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 64'hA5A5_0000_0002, 1'b1, 1'b1, 1'b0, 1'b1, 64'hA5A5_0000_0001};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 64'h0,            1'b0, 1'b1, 1'b1, 1'b0, 64'hA5A5_0000_0002};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 64'h0,            1'b0, 1'b0, 1'b1, 1'b0, 64'hA5A5_0000_0002};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 64'hA5A5_0000_0003, 1'b1, 1'b0, 1'b0, 1'b1, 64'hA5A5_0000_0002};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 64'hA5A5_0000_0004, 1'b0, 1'b0, 1'b1, 1'b0, 64'hA5A5_0000_0002};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 64'h0,            1'b0, 1'b0, 1'b1, 1'b0, 64'hA5A5_0000_0002};

    rst_n = 1'b1; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset");
    chk("reset.wallow", 64'(wallow), 64'(0));
    chk("reset.rallow", 64'(rallow), 64'(0));
    rst_n = 1'b1;

    // Table-driven short sequence from reset
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d, gw, gr);
      chk($sformatf("tbl%0d.wallow", i), 64'(gw), 64'(tbl[i].ew));
      chk($sformatf("tbl%0d.rallow", i), 64'(gr), 64'(tbl[i].er));
      chk($sformatf("tbl%0d.empty", i),  64'(empty), 64'(tbl[i].ee));
      chk($sformatf("tbl%0d.aempty", i), 64'(almost_empty), 64'(tbl[i].eae));
      chk($sformatf("tbl%0d.dout", i),   dout, tbl[i].edout);
    end

    // Fill and drain
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 64'(i), gw, gr);
      if (i == DEPTH - 2) chk("fill.afull31", 64'(almost_full), 64'(1));
    end
    chk("fill.full32", 64'(full), 64'(1));
    cyc(1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF, gw, gr);
    chk("fill.w33_refused", 64'(gw), 64'(0));
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0, gw, gr);
      chk("drain.order", dout, 64'(i));
      if (i == DEPTH - 2) chk("drain.aempty", 64'(almost_empty), 64'(1));
    end
    chk("drain.empty", 64'(empty), 64'(1));

    // Read while empty
    hold_d = dout; hold_a = raddr;
    cyc(1'b0, 1'b1, 1'b0, '0, gw, gr);
    chk("rdempty.rallow", 64'(gr), 64'(0));
    chk("rdempty.dout", dout, hold_d);
    chk("rdempty.raddr", 64'(raddr), 64'(hold_a));

    // Simultaneous on empty: write only
    cyc(1'b1, 1'b1, 1'b0, 64'h1234_5678, gw, gr);
    chk("simE.wallow", 64'(gw), 64'(1));
    chk("simE.rallow", 64'(gr), 64'(0));
    chk("simE.count1", 64'(almost_empty), 64'(1));
    drain();

    // Simultaneous on full: read only
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 64'h100 + 64'(i), gw, gr);
    cyc(1'b1, 1'b1, 1'b0, 64'hBAD, gw, gr);
    chk("simF.wallow", 64'(gw), 64'(0));
    chk("simF.rallow", 64'(gr), 64'(1));
    chk("simF.count31", 64'(almost_full), 64'(1));
    drain();

    // Simultaneous at count 5
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 64'h500 + 64'(i), gw, gr);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 64'h600 + 64'(i), gw, gr);
      chk("sim5.count", 64'(5'(waddr - raddr)), 64'(5));
    end
    drain();

    // Random streaming across wraps
    pushed = 0;
    for (int k = 0; k < 3000 && pushed < 100; k++) begin
      word = {$urandom, $urandom};
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'b0, word, gw, gr);
      if (gw) pushed++;
    end
    chk("rand.pushed100", 64'(pushed >= 100), 64'(1));
    drain();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 64'h700 + 64'(i), gw, gr);
    cyc(1'b0, 1'b1, 1'b0, '0, gw, gr);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_state("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 64'hCAFE_F00D, gw, gr);
    cyc(1'b0, 1'b1, 1'b0, '0, gw, gr);
    chk("postreset.dout", dout, 64'hCAFE_F00D);

    // Clear with concurrent write
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 64'h800 + 64'(i), gw, gr);
    hold_d = dout;
    cyc(1'b1, 1'b0, 1'b1, 64'h999, gw, gr);
    chk("clear.wallow", 64'(gw), 64'(0));
    chk("clear.empty", 64'(empty), 64'(1));
    chk("clear.waddr", 64'(waddr), 64'(0));
    chk("clear.raddr", 64'(raddr), 64'(0));
    chk("clear.dout", dout, hold_d);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
